// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and FSM state types
// for the UART echo buffer and its FIFO.
package uart_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    R_IDLE,
    R_CLR,
    R_WAIT
  } rx_state_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_LOAD,
    T_ARM,
    T_BUSY
  } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: show-ahead synchronous byte FIFO, 2^DEPTH_LOG2 deep.
// Ports: push/pop/din in; dout (head), full, empty, count out.
module byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT =
    (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ONE = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_push;
  logic                  w_pop;

  assign full  = (r_count == FULL_CNT);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  // Guard both sides so the FIFO stays consistent
  // even if a caller misuses it.
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_echo_buffer.sv
// uart_echo_buffer: acks UART rx bytes, queues them and replays
// them to the UART tx at line rate, optionally expanding CR->CRLF.
// Ports: clk_50m, rst; rx_data/rx_rdy in, rx_rdy_clr out;
// tx_din/tx_wr_en out, tx_busy in; fifo_count, drop_cnt out.
module uart_echo_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter bit CRLF       = 1'b1
) (
  input  logic                clk_50m,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_rdy,
  output logic                rx_rdy_clr,
  output logic [7:0]          tx_din,
  output logic                tx_wr_en,
  input  logic                tx_busy,
  output logic [DEPTH_LOG2:0] fifo_count,
  output logic [7:0]          drop_cnt
);

  rx_state_t  r_rx_state;
  rx_state_t  w_rx_next;
  tx_state_t  r_tx_state;
  tx_state_t  w_tx_next;

  logic [7:0] r_tx_din;
  logic [7:0] r_drop_cnt;
  logic       r_pending_lf;

  logic       w_push;
  logic       w_drop;
  logic       w_pop;
  logic       w_load_head;
  logic       w_load_lf;
  logic [7:0] w_dout;
  logic       w_full;
  logic       w_empty;

  byte_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk  (clk_50m),
    .rst  (rst),
    .push (w_push),
    .pop  (w_pop),
    .din  (rx_data),
    .dout (w_dout),
    .full (w_full),
    .empty(w_empty),
    .count(fifo_count)
  );

  // A full FIFO still acknowledges the byte so the
  // UART never stalls; the byte is counted as dropped.
  always_comb begin
    w_rx_next = r_rx_state;
    w_push    = 1'b0;
    w_drop    = 1'b0;
    unique case (r_rx_state)
      R_IDLE: begin
        if (rx_rdy) begin
          w_push    = ~w_full;
          w_drop    = w_full;
          w_rx_next = R_CLR;
        end
      end
      R_CLR: w_rx_next = R_WAIT;
      // Wait for rx_rdy to drop so one byte is
      // never taken twice.
      R_WAIT: begin
        if (!rx_rdy) w_rx_next = R_IDLE;
      end
      default: w_rx_next = R_IDLE;
    endcase
  end

  // T_ARM is a guard cycle: the transmitter may not
  // have raised tx_busy yet right after the strobe.
  always_comb begin
    w_tx_next   = r_tx_state;
    w_pop       = 1'b0;
    w_load_head = 1'b0;
    w_load_lf   = 1'b0;
    unique case (r_tx_state)
      T_IDLE: begin
        if (!w_empty && !tx_busy) begin
          w_pop       = 1'b1;
          w_load_head = 1'b1;
          w_tx_next   = T_LOAD;
        end
      end
      T_LOAD: w_tx_next = T_ARM;
      T_ARM:  w_tx_next = T_BUSY;
      T_BUSY: begin
        if (!tx_busy) begin
          if (r_pending_lf) begin
            w_load_lf = 1'b1;
            w_tx_next = T_LOAD;
          end else begin
            w_tx_next = T_IDLE;
          end
        end
      end
      default: w_tx_next = T_IDLE;
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_rx_state   <= R_IDLE;
      r_tx_state   <= T_IDLE;
      r_tx_din     <= '0;
      r_pending_lf <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_rx_state <= w_rx_next;
      r_tx_state <= w_tx_next;
      if (w_load_head) begin
        r_tx_din     <= w_dout;
        r_pending_lf <= CRLF && (w_dout == ASCII_CR);
      end else if (w_load_lf) begin
        r_tx_din     <= ASCII_LF;
        r_pending_lf <= 1'b0;
      end
      if (w_drop && (r_drop_cnt != 8'hFF))
        r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign rx_rdy_clr = (r_rx_state == R_CLR);
  assign tx_wr_en   = (r_tx_state == T_LOAD);
  assign tx_din     = r_tx_din;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_uart_echo_buffer.sv
// tb_uart_echo_buffer: vectors, corner sequences and random
// traffic against a stream-level model of the echo buffer.
module tb_uart_echo_buffer;

  typedef logic [7:0] u8_t;
  typedef u8_t bq_t[$];

  typedef struct {
    u8_t rx;
    int  n1;
    int  n0;
    u8_t second;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       force_busy;
  logic       busy1, busy0;
  logic       clr1, clr0;
  logic [7:0] din1, din0;
  logic       wr1, wr0;
  logic [4:0] cnt1, cnt0;
  logic [7:0] drop1, drop0;

  int errors = 0;
  int checks = 0;
  int busy_min = 2;
  int busy_max = 12;
  int bcnt1 = 0;
  int bcnt0 = 0;
  int clr_cnt = 0;
  int viol = 0;
  int gap = 100;
  logic held_v = 1'b0;
  u8_t  held = '0;
  bq_t  got1, got0;

  always #10 clk = ~clk;

  uart_echo_buffer #(.DEPTH_LOG2(4), .CRLF(1'b1)) u_dut1 (
    .clk_50m(clk), .rst(rst),
    .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_rdy_clr(clr1),
    .tx_din(din1), .tx_wr_en(wr1), .tx_busy(busy1),
    .fifo_count(cnt1), .drop_cnt(drop1)
  );

  uart_echo_buffer #(.DEPTH_LOG2(4), .CRLF(1'b0)) u_dut0 (
    .clk_50m(clk), .rst(rst),
    .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_rdy_clr(clr0),
    .tx_din(din0), .tx_wr_en(wr0), .tx_busy(busy0),
    .fifo_count(cnt0), .drop_cnt(drop0)
  );

  // Transmitter models: busy for a random span after each strobe.
  always @(posedge clk) begin
    if (wr1) bcnt1 <= int'($urandom_range(busy_max, busy_min));
    else if (bcnt1 != 0) bcnt1 <= bcnt1 - 1;
    if (wr0) bcnt0 <= int'($urandom_range(busy_max, busy_min));
    else if (bcnt0 != 0) bcnt0 <= bcnt0 - 1;
  end

  assign busy1 = force_busy | (bcnt1 != 0);
  assign busy0 = force_busy | (bcnt0 != 0);

  // Capture transmitted bytes and watch strobe protocol rules.
  always @(negedge clk) begin
    if (wr1) got1.push_back(din1);
    if (wr0) got0.push_back(din0);
    if (clr1) clr_cnt <= clr_cnt + 1;
    if (rst) begin
      held_v <= 1'b0;
      gap    <= 100;
    end else begin
      gap <= wr1 ? 1 : (gap < 100 ? gap + 1 : gap);
      if (wr1) begin
        held   <= din1;
        held_v <= 1'b1;
        if (gap < 3 || busy1) viol <= viol + 1;
      end else if (held_v && busy1) begin
        if (din1 !== held) viol <= viol + 1;
      end else begin
        held_v <= 1'b0;
      end
    end
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bq_t expand(input bq_t in, input bit crlf);
    bq_t out;
    foreach (in[i]) begin
      out.push_back(in[i]);
      if (crlf && in[i] == 8'h0D) out.push_back(8'h0A);
    end
    return out;
  endfunction

  function automatic bq_t tail(input bq_t q, input int from);
    bq_t out;
    for (int i = from; i < q.size(); i++) out.push_back(q[i]);
    return out;
  endfunction

  task automatic cmp_stream(input string name, input bq_t got,
                            input bq_t exp);
    int k;
    check({name, "_len"}, got.size(), exp.size());
    if (got.size() > 0 && exp.size() > 0) begin
      k = 0;
      for (int i = 0; i < got.size() && i < exp.size(); i++)
        if (got[i] !== exp[i]) begin k = i; break; end
      check({name, "_data"}, got[k], exp[k]);
    end
  endtask

  task automatic send(input u8_t b);
    bit ok = 0;
    rx_data = b;
    rx_rdy  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (clr1) begin ok = 1; break; end
    end
    if (!ok) check("ack_timeout", 0, 1);
    rx_rdy = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain();
    int quiet = 0;
    for (int c = 0; c < 3000 && quiet < 8; c++) begin
      @(negedge clk);
      if (cnt1 == 0 && cnt0 == 0 && !busy1 && !busy0 && !wr1 && !wr0)
        quiet++;
      else
        quiet = 0;
    end
    if (quiet < 8) check("drain_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    rx_rdy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[5];
    bq_t  in_q, exp_q;
    int   b1, b0, c, s;
    u8_t  b;

    tbl[0] = '{8'h41, 1, 1, 8'h00};
    tbl[1] = '{8'h0D, 2, 1, 8'h0A};
    tbl[2] = '{8'h0A, 1, 1, 8'h00};
    tbl[3] = '{8'hFF, 1, 1, 8'h00};
    tbl[4] = '{8'h00, 1, 1, 8'h00};

    rst = 1'b1; rx_rdy = 1'b0; rx_data = '0; force_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_clr", clr1, 0);
    check("rst_wr", wr1, 0);
    check("rst_din", din1, 0);
    check("rst_count", cnt1, 0);
    check("rst_drop", drop1, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single-byte vectors, 10-cycle busy.
    busy_min = 10; busy_max = 10;
    foreach (tbl[i]) begin
      b1 = got1.size(); b0 = got0.size(); c = clr_cnt;
      send(tbl[i].rx);
      drain();
      check("vec_n1", got1.size() - b1, tbl[i].n1);
      if (got1.size() > b1) check("vec_b1", got1[b1], tbl[i].rx);
      if (tbl[i].n1 == 2 && got1.size() > b1 + 1)
        check("vec_lf", got1[b1+1], tbl[i].second);
      check("vec_n0", got0.size() - b0, tbl[i].n0);
      if (got0.size() > b0) check("vec_b0", got0[b0], tbl[i].rx);
      check("vec_acks", clr_cnt - c, 1);
      check("vec_count", cnt1, 0);
    end
    busy_min = 2; busy_max = 12;

    // Burst of 16 into a blocked transmitter.
    do_reset();
    b1 = got1.size(); b0 = got0.size();
    in_q.delete();
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_q.push_back(u8_t'(i));
      send(u8_t'(i));
    end
    check("burst_count", cnt1, 16);
    check("burst_drop", drop1, 0);
    force_busy = 1'b0;
    drain();
    cmp_stream("burst1", tail(got1, b1), expand(in_q, 1'b1));
    cmp_stream("burst0", tail(got0, b0), expand(in_q, 1'b0));

    // Overflow: 20 bytes, 4 dropped, every one acknowledged.
    do_reset();
    b1 = got1.size(); c = clr_cnt;
    in_q.delete();
    force_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i < 16) in_q.push_back(u8_t'(8'h20 + i));
      send(u8_t'(8'h20 + i));
    end
    check("ovf_count", cnt1, 16);
    check("ovf_drop", drop1, 4);
    check("ovf_drop0", drop0, 4);
    check("ovf_acks", clr_cnt - c, 20);
    force_busy = 1'b0;
    drain();
    cmp_stream("ovf", tail(got1, b1), expand(in_q, 1'b1));

    // Drop counter saturation.
    do_reset();
    force_busy = 1'b1;
    for (int i = 0; i < 16 + 257; i++) send(u8_t'(i));
    check("sat_drop", drop1, 255);
    force_busy = 1'b0;
    drain();

    // Push in the same cycle as a pop at count 1.
    do_reset();
    b1 = got1.size();
    force_busy = 1'b1;
    send(8'h51);
    check("simul_pre", cnt1, 1);
    rx_data = 8'h52; rx_rdy = 1'b1; force_busy = 1'b0;
    @(negedge clk);
    check("simul_count", cnt1, 1);
    check("simul_ack", clr1, 1);
    rx_rdy = 1'b0;
    repeat (2) @(negedge clk);
    drain();
    in_q.delete(); in_q.push_back(8'h51); in_q.push_back(8'h52);
    cmp_stream("simul", tail(got1, b1), expand(in_q, 1'b1));

    // Reset while busy with 5 bytes still queued.
    do_reset();
    busy_min = 80; busy_max = 80;
    b1 = got1.size();
    for (int i = 0; i < 6; i++) send(u8_t'(8'h61 + i));
    check("mid_queued", cnt1, 5);
    check("mid_strobes", got1.size() - b1, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_clr", clr1, 0);
    check("mid_rst_wr", wr1, 0);
    check("mid_rst_din", din1, 0);
    check("mid_rst_count", cnt1, 0);
    check("mid_rst_drop", drop1, 0);
    rst = 1'b0;
    s = got1.size();
    repeat (100) @(negedge clk);
    check("mid_no_strobe", got1.size() - s, 0);
    busy_min = 2; busy_max = 12;
    send(8'h77);
    drain();
    in_q.delete(); in_q.push_back(8'h77);
    cmp_stream("mid_after", tail(got1, s), expand(in_q, 1'b1));

    // Random bursts against the stream model.
    do_reset();
    b1 = got1.size(); b0 = got0.size();
    in_q.delete();
    for (int r = 0; r < 30; r++) begin
      for (int n = int'($urandom_range(10, 1)); n > 0; n--) begin
        b = ($urandom % 4 == 0) ? 8'h0D : u8_t'($urandom);
        in_q.push_back(b);
        send(b);
        repeat ($urandom_range(4, 0)) @(negedge clk);
      end
      drain();
    end
    cmp_stream("rand1", tail(got1, b1), expand(in_q, 1'b1));
    cmp_stream("rand0", tail(got0, b0), expand(in_q, 1'b0));
    check("rand_drop", drop1, 0);
    check("protocol_viol", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
